// File: rtl/mem_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : mem_addr_gen
// Description : Memory address register with single-step increment and burst
//               address generation. Loads from MBR or PC, increments, or walks
//               consecutive addresses on to_memory, one per accepted
//               mem_req/mem_ack beat. Control bits are decoded from the shared
//               control_signal bus at parametrised positions.
// Ports       : clk            - clock, rising edge
//               rst_n          - asynchronous active-low reset
//               control_signal - shared control word (LD_MBR/LD_PC/INC/BURST/ABORT)
//               from_MBR       - address source from MBR
//               from_PC        - address source from PC
//               burst_len      - beat count, sampled when a burst starts
//               mem_ack        - memory accepts the current beat
//               to_memory      - registered address to memory
//               mem_req        - beat request, high throughout a burst
//               busy           - high while a burst is in progress
//               burst_done     - one-cycle pulse after the final beat is accepted
// Revision    : 1.0 - initial release
// ============================================================================
module mem_addr_gen #(
    parameter int ADDR_W    = 8,
    parameter int CTRL_W    = 32,
    parameter int LEN_W     = 4,
    parameter int LD_MBR    = 5,
    parameter int LD_PC     = 10,
    parameter int INC_BIT   = 11,
    parameter int BURST_BIT = 12,
    parameter int ABORT_BIT = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CTRL_W-1:0] control_signal,
    input  logic [ADDR_W-1:0] from_MBR,
    input  logic [ADDR_W-1:0] from_PC,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] to_memory,
    output logic              mem_req,
    output logic              busy,
    output logic              burst_done
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] c_addr_one = ADDR_W'(1);
    localparam logic [LEN_W-1:0]  c_len_one  = LEN_W'(1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [LEN_W-1:0]  r_count;
    logic [LEN_W-1:0]  w_count_nxt;
    logic              r_req;
    logic              w_req_nxt;
    logic              r_busy;
    logic              w_busy_nxt;
    logic              r_done;
    logic              w_done_nxt;

    logic              w_ld_mbr;
    logic              w_ld_pc;
    logic              w_inc;
    logic              w_burst;
    logic              w_abort;
    logic              w_unused_ctrl;

    assign w_ld_mbr = control_signal[LD_MBR];
    assign w_ld_pc  = control_signal[LD_PC];
    assign w_inc    = control_signal[INC_BIT];
    assign w_burst  = control_signal[BURST_BIT];
    assign w_abort  = control_signal[ABORT_BIT];

    // Only a handful of control bits belong to this block; the rest of the
    // shared bus is intentionally ignored.
    assign w_unused_ctrl = ^control_signal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_count <= '0;
            r_req   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_count <= w_count_nxt;
            r_req   <= w_req_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_count_nxt = r_count;
        w_req_nxt   = r_req;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_ld_mbr) begin
                    w_addr_nxt = from_MBR;
                end else if (w_ld_pc) begin
                    w_addr_nxt = from_PC;
                end else if (w_inc) begin
                    w_addr_nxt = r_addr + c_addr_one;
                end else if (w_burst && (burst_len != '0)) begin
                    // Burst starts from whatever address is already loaded.
                    w_count_nxt = burst_len;
                    w_req_nxt   = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_BURST;
                end
            end

            S_BURST: begin
                if (mem_ack) begin
                    if (r_count > c_len_one) begin
                        w_addr_nxt  = r_addr + c_addr_one;
                        w_count_nxt = r_count - c_len_one;
                    end else begin
                        // Final beat: address stays at base+len-1.
                        w_count_nxt = '0;
                        w_req_nxt   = 1'b0;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                // Abort wins over continuing, but a same-cycle ack has already
                // advanced the address (and signalled completion if final).
                if (w_abort) begin
                    w_req_nxt   = 1'b0;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_req_nxt   = 1'b0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign to_memory  = r_addr;
    assign mem_req    = r_req;
    assign busy       = r_busy;
    assign burst_done = r_done;

endmodule
`default_nettype wire
